mul_share_arb: RTL
==================

# mul_share_arb

Shares one pipelined 64x64 multiplier between NUM_REQ requesters, such as eBPF core ALUs, in the cl_dram_dma_with_cpu design.
- Arbitrates round-robin and accepts at most one operation per cycle.
- Tags each operation through a fixed-latency multiply pipeline.
- Holds each result in a per-requester response slot until that requester takes it.
- Each requester has at most one operation outstanding, so the pipeline never stalls.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters, 2..8.
- LAT, 3: multiply pipeline depth in cycles, 1..6.

Ports:
- clk  in  1: single clock.
- rst  in  1: synchronous reset, active-high.
- req_valid  in  NUM_REQ: per-requester operation valid.
- req_ready  out  NUM_REQ: per-requester accept.
- req_a  in  NUM_REQ x 64: operand A.
- req_b  in  NUM_REQ x 64: operand B.
- req_alu32  in  NUM_REQ: 32-bit ALU mode.
- req_hi  in  NUM_REQ: return the upper product half. Present only with MUL_ARB_HI_EN.
- rsp_valid  out  NUM_REQ: result held.
- rsp_data  out  NUM_REQ x 64: result.
- rsp_ready  in  NUM_REQ: result consumed.

## Operation
- Eligibility: requester i is eligible when req_valid[i]=1 and busy[i]=0.
- busy[i] is set on accept and cleared on the response handshake.
- Grant: the first eligible index searching upward from rr_ptr, with wraparound.
- req_ready is one-hot on the granted index, or all-zero when no requester is eligible.
- Accept: req_valid[i] & req_ready[i] at a rising edge.
  - Operands, mode and tag i enter stage 1.
  - busy[i] is set.
  - rr_ptr becomes (i+1) mod NUM_REQ.
- No accept: rr_ptr holds.
- Arithmetic, unsigned:
  - alu32=0: product P = a*b (128 bits); result is P[63:0].
  - alu32=1: result is {32'b0, (a[31:0]*b[31:0])[31:0]}.
  - hi=1 (macro only): result is P[127:64]. With alu32=1, hi is ignored.
- Pipeline exit: the tagged result is written into slot[tag] and rsp_valid[tag] is set.
  - rsp_data[tag] stays stable until rsp_valid[tag] & rsp_ready[tag].
  - At that edge rsp_valid and busy clear together.
- A slot can never be overwritten while valid, because the one-outstanding rule guarantees it. Verify with an assertion.
- Requester inputs must hold stable while valid and not ready; this is a standard valid/ready contract.

## Timing
- Reset values:
  - req_ready=0 during the reset cycle; it is combinational afterward.
  - rsp_valid=0, rsp_data=0, busy=0, rr_ptr=0.
  - All pipeline valids are 0.
- Reset mid-operation discards in-flight operations and held results. No response is produced for them.
- Latency: accepted at edge E0, rsp_valid rises after edge E_LAT, i.e. LAT cycles.
- Throughput: one accept per cycle, aggregated across requesters.
- Same-cycle response handshake and new req_valid from the same requester:
  - Not accepted in that cycle, since busy is still 1.
  - Earliest re-accept is the next cycle.
- rsp_ready=1 while rsp_valid=0 has no effect.
- rsp_ready high on the cycle rsp_valid rises consumes the result at the next edge, with no minimum hold.

## Configuration
- MUL_ARB_HI_EN defined:
  - req_hi ports exist and the pipeline carries the hi bit.
  - The full 128-bit product is computed.
- MUL_ARB_HI_EN undefined:
  - No req_hi ports.
  - Only the low 64 bits are computed, which saves DSPs.
  - Behaviour is identical to hi=0.

## Structure
- mul_arb_pkg holds:
  - MUL_W=64 and the TAG_W function $clog2(NUM_REQ).
  - Typedef mul_op_t {a, b, alu32, hi, tag}.
  - Typedef mul_mode_e.
- Sub-module mul_pipe: LAT-stage registered multiplier carrying valid and tag alongside the data.
  - Takes no backpressure.
  - Reset clears only the valids.
- The top level holds the arbiter, rr_ptr, busy and the response slots.

## Test plan
- Single op: req 0, a=3, b=5, alu32=0 -> accepted next edge; rsp_valid[0] after LAT cycles; rsp_data=15.
- Wide/32-bit: a=64'hFFFF_FFFF_FFFF_FFFF, b=2 -> 64'hFFFF_FFFF_FFFF_FFFE. Same operands with alu32=1 -> 64'h0000_0000_FFFF_FFFE. With MUL_ARB_HI_EN and hi=1 -> 64'h1.
- Fairness: all 4 requesters valid continuously, each consuming rsp immediately.
  - Grant order is 0,1,2,3,0...
  - Each requester is granted exactly once per 4 accepts.
- Backpressure: requester 2 holds rsp_ready=0 for 10 cycles.
  - rsp_data[2] stays stable.
  - req_ready[2] stays 0.
  - The other requesters continue at full rate.
- Reset mid-flight: assert rst with 3 ops in the pipe.
  - All rsp_valid=0 and rr_ptr=0.
  - No stale response appears afterward.
  - The first post-reset op returns its correct result.
- Same-cycle handshake: rsp handshake on requester 1 with req_valid[1]=1 -> accept occurs exactly one cycle later.

Source files
------------

// File: rtl/mul_arb_pkg.sv
// Shared constants and types for the shared 64x64 multiplier arbiter.
// MUL_ARB_HI_EN selects whether the upper product half can be returned.
package mul_arb_pkg;

    localparam int MUL_W   = 64;
    localparam int TAG_MAX = 3;

    function automatic int tag_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        MODE_LO  = 2'd0,
        MODE_A32 = 2'd1,
        MODE_HI  = 2'd2
    } mul_mode_e;

    typedef struct packed {
        logic [MUL_W-1:0]   a;
        logic [MUL_W-1:0]   b;
        logic               alu32;
        logic               hi;
        logic [TAG_MAX-1:0] tag;
    } mul_op_t;

    // alu32 wins over hi
    function automatic mul_mode_e op_mode(input logic alu32, input logic hi);
        if (alu32) return MODE_A32;
        if (hi) return MODE_HI;
        return MODE_LO;
    endfunction

endpackage

// File: rtl/mul_pipe.sv
// Fixed-latency multiply pipeline carrying valid and tag; no backpressure.
// MUL_ARB_HI_EN widens the product to 128 bits for the upper-half mode.
module mul_pipe
    import mul_arb_pkg::*;
#(
    parameter int LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [MUL_W-1:0]   in_a,
    input  logic [MUL_W-1:0]   in_b,
    input  logic               in_alu32,
    input  logic               in_hi,
    input  logic [TAG_MAX-1:0] in_tag,
    output logic               out_valid,
    output logic [TAG_MAX-1:0] out_tag,
    output logic [MUL_W-1:0]   out_data
);

`ifdef MUL_ARB_HI_EN
    logic [2*MUL_W-1:0] prod;
    assign prod = {{MUL_W{1'b0}}, in_a} * {{MUL_W{1'b0}}, in_b};
`else
    logic [MUL_W-1:0] prod;
    assign prod = in_a * in_b;
`endif

    mul_mode_e        mode;
    logic [MUL_W-1:0] res;

    // low 32 bits of the 64-bit product equal the 32x32 product's low half
    always_comb begin
        mode = op_mode(in_alu32, in_hi);
        res  = prod[MUL_W-1:0];
        unique case (mode)
            MODE_A32: res = {32'b0, prod[31:0]};
`ifdef MUL_ARB_HI_EN
            MODE_HI:  res = prod[2*MUL_W-1:MUL_W];
`endif
            default:  res = prod[MUL_W-1:0];
        endcase
    end

    logic [LAT-1:0]     v_q, v_d;
    logic [TAG_MAX-1:0] t_q [LAT];
    logic [TAG_MAX-1:0] t_d [LAT];
    logic [MUL_W-1:0]   r_q [LAT];
    logic [MUL_W-1:0]   r_d [LAT];

    always_comb begin
        v_d[0] = in_valid;
        t_d[0] = in_tag;
        r_d[0] = res;
        for (int k = 1; k < LAT; k++) begin
            v_d[k] = v_q[k-1];
            t_d[k] = t_q[k-1];
            r_d[k] = r_q[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) v_q <= '0;
        else     v_q <= v_d;
        t_q <= t_d;
        r_q <= r_d;
    end

    assign out_valid = v_q[LAT-1];
    assign out_tag   = t_q[LAT-1];
    assign out_data  = r_q[LAT-1];

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin sharing of one pipelined multiplier with per-requester result slots.
// MUL_ARB_HI_EN adds req_hi ports for upper-half results.
module mul_share_arb
    import mul_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LAT     = 3
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ-1:0][MUL_W-1:0] req_a,
    input  logic [NUM_REQ-1:0][MUL_W-1:0] req_b,
    input  logic [NUM_REQ-1:0]            req_alu32,
`ifdef MUL_ARB_HI_EN
    input  logic [NUM_REQ-1:0]            req_hi,
`endif
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [NUM_REQ-1:0][MUL_W-1:0] rsp_data,
    input  logic [NUM_REQ-1:0]            rsp_ready
);

    localparam int TAG_W = tag_w(NUM_REQ);

    logic [NUM_REQ-1:0]            busy_q, busy_d;
    logic [TAG_W-1:0]              rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0]            rsp_valid_q, rsp_valid_d;
    logic [NUM_REQ-1:0][MUL_W-1:0] rsp_data_q, rsp_data_d;

    logic [NUM_REQ-1:0] elig, gnt, fire, done, hit;
    logic [TAG_W-1:0]   idx, gnt_idx;
    mul_op_t            op;
    logic               pipe_v;
    logic [TAG_MAX-1:0] pipe_tag;
    logic [MUL_W-1:0]   pipe_data;

    always_comb begin
        elig    = req_valid & ~busy_q;
        gnt     = '0;
        gnt_idx = '0;
        idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = TAG_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (gnt == '0 && elig[idx]) begin
                gnt[idx] = 1'b1;
                gnt_idx  = idx;
            end
        end
        req_ready = rst ? '0 : gnt;
    end

    always_comb begin
        op = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (gnt[k]) begin
                op.a     = req_a[k];
                op.b     = req_b[k];
                op.alu32 = req_alu32[k];
`ifdef MUL_ARB_HI_EN
                op.hi    = req_hi[k];
`endif
            end
        end
        op.tag = TAG_MAX'(gnt_idx);
    end

    mul_pipe #(.LAT(LAT)) u_pipe (
        .clk      (clk),
        .rst      (rst),
        .in_valid (|fire),
        .in_a     (op.a),
        .in_b     (op.b),
        .in_alu32 (op.alu32),
        .in_hi    (op.hi),
        .in_tag   (op.tag),
        .out_valid(pipe_v),
        .out_tag  (pipe_tag),
        .out_data (pipe_data)
    );

    // accept and response handshake never coincide on one requester
    always_comb begin
        fire        = req_valid & req_ready;
        done        = rsp_valid_q & rsp_ready;
        busy_d      = (busy_q | fire) & ~done;
        rr_ptr_d    = (|fire) ? TAG_W'((int'(gnt_idx) + 1) % NUM_REQ) : rr_ptr_q;
        hit         = '0;
        rsp_data_d  = rsp_data_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            hit[k] = pipe_v && (pipe_tag == TAG_MAX'(k));
            if (hit[k]) rsp_data_d[k] = pipe_data;
        end
        rsp_valid_d = (rsp_valid_q & ~done) | hit;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q      <= '0;
            rr_ptr_q    <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            busy_q      <= busy_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

    a_no_overwrite: assert property (
        @(posedge clk) disable iff (rst) !(|(hit & rsp_valid_q)));

endmodule
